// File: rtl/jam_cost_server.sv
// Responder for the JAM cost-table interface: loads an 8x8 cost table over a
// valid/ready stream, serves registered (W,J) reads, and scores the JAM result.
module jam_cost_server #(
  parameter int COST_W  = 7,
  parameter int TIMEOUT = 100000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_valid,
  input  logic [COST_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [9:0]        exp_min,
  input  logic [3:0]        exp_cnt,
  output logic              jam_rst,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [3:0]        MatchCount,
  input  logic [9:0]        MinCost,
  output logic              done,
  output logic              pass,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SERVE,
    S_DONE
  } state_t;

  state_t            state;
  logic [5:0]        idx;
  logic [CNT_W-1:0]  cnt;
  logic [9:0]        exp_min_q;
  logic [3:0]        exp_cnt_q;
  logic [COST_W-1:0] mem [64];
  logic              ld_fire;

  assign ld_fire = (state == S_LOAD) && ld_valid && ld_ready;

  // Table storage carries no reset; reads are only possible after a full reload.
  always_ff @(posedge CLK) begin
    if (ld_fire) begin
      mem[idx] <= ld_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_LOAD;
      idx       <= '0;
      cnt       <= '0;
      exp_min_q <= '0;
      exp_cnt_q <= '0;
      ld_ready  <= 1'b1;
      jam_rst   <= 1'b1;
      Cost      <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (ld_fire) begin
            idx <= idx + 6'd1;
            if (idx == 6'd63) begin
              exp_min_q <= exp_min;
              exp_cnt_q <= exp_cnt;
              ld_ready  <= 1'b0;
              jam_rst   <= 1'b0;
              state     <= S_SERVE;
            end
          end
        end
        S_SERVE: begin
          Cost <= mem[{W, J}];
          if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
          // Valid takes priority over an expiring counter in the same cycle.
          if (Valid) begin
            done    <= 1'b1;
            pass    <= (MinCost == exp_min_q) && (MatchCount == exp_cnt_q);
            timeout <= 1'b0;
            jam_rst <= 1'b1;
            Cost    <= '0;
            state   <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
            jam_rst <= 1'b1;
            Cost    <= '0;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          Cost     <= '0;
          ld_ready <= 1'b0;
          jam_rst  <= 1'b1;
        end
        default: begin
          state <= S_DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: table-driven reads through a
// scoreboard queue plus hand-written load/score/timeout/reset sequences.
module tb_jam_cost_server;

  localparam int COST_W = 7;
  localparam int TMO    = 100;

  logic              CLK = 1'b0;
  logic              RST;
  logic              ld_valid;
  logic [COST_W-1:0] ld_data;
  logic              ld_ready;
  logic [9:0]        exp_min;
  logic [3:0]        exp_cnt;
  logic              jam_rst;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [COST_W-1:0] Cost;
  logic              Valid;
  logic [3:0]        MatchCount;
  logic [9:0]        MinCost;
  logic              done;
  logic              pass;
  logic              timeout;

  jam_cost_server #(.COST_W(COST_W), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .exp_min(exp_min), .exp_cnt(exp_cnt), .jam_rst(jam_rst),
    .W(W), .J(J), .Cost(Cost),
    .Valid(Valid), .MatchCount(MatchCount), .MinCost(MinCost),
    .done(done), .pass(pass), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]        w;
    logic [2:0]        j;
    logic [COST_W-1:0] cost;
  } rd_vec_t;

  typedef struct {
    string             name;
    logic [COST_W-1:0] cost;
  } sb_t;

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [COST_W-1:0] tbl [64];
  rd_vec_t           vecs [8];
  sb_t               sbq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic model_pass(input logic [9:0] mc, input logic [3:0] cnt);
    return (mc == exp_min) && (cnt == exp_cnt);
  endfunction

  task automatic fill_std();
    for (int k = 0; k < 64; k++) tbl[k] = ((k >> 3) == (k & 7)) ? 7'd0 : 7'd10;
    tbl[29] = 7'd42;
  endtask

  // Called just after an edge; checks the asynchronous reset values immediately.
  task automatic do_reset(input string tag);
    RST = 1'b1;
    ld_valid = 1'b0; Valid = 1'b0; W = '0; J = '0;
    #2;
    check({tag, "_ld_ready"}, ld_ready, 1);
    check({tag, "_jam_rst"},  jam_rst,  1);
    check({tag, "_done"},     done,     0);
    check({tag, "_pass"},     pass,     0);
    check({tag, "_timeout"},  timeout,  0);
    check({tag, "_cost"},     Cost,     0);
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  // Streams tbl[0..n-1]; on return (full load) the bench sits #1 after the 64th accept edge.
  task automatic load(input int n, input bit gaps);
    int k = 0;
    int guard = 0;
    int not_ready = 0;
    bit rdy;
    while (k < n) begin
      if (guard > 2000) begin
        n_checks++; n_fail++;
        $display("FAIL load_bound: got %0d words expected %0d", k, n);
        break;
      end
      ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_data  = tbl[k];
      rdy      = ld_ready;
      @(posedge CLK); #1;
      guard++;
      if (ld_valid) begin
        if (rdy) k++;
        else not_ready++;
      end
    end
    ld_valid = 1'b0;
    check("ld_ready_during_load", not_ready, 0);
    if (n == 64) begin
      check("ld_ready_drop", ld_ready, 0);
      check("jam_rst_drop",  jam_rst,  0);
    end
  endtask

  task automatic read_one(input string name, input logic [2:0] w, input logic [2:0] j,
                          input logic [COST_W-1:0] exp);
    sb_t e;
    W = w; J = j;
    sbq.push_back('{name, exp});
    @(posedge CLK); #1;
    e = sbq.pop_front();
    check(e.name, Cost, e.cost);
  endtask

  task automatic send_result(input logic [9:0] mc, input logic [3:0] cnt);
    Valid = 1'b1; MinCost = mc; MatchCount = cnt;
    @(posedge CLK); #1;
    Valid = 1'b0;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; ld_valid = 1'b0; ld_data = '0; Valid = 1'b0;
    W = '0; J = '0; MinCost = '0; MatchCount = '0;
    exp_min = 10'd0; exp_cnt = 4'd1;
    vecs[0] = '{3'd3, 3'd5, 7'd42};
    vecs[1] = '{3'd5, 3'd3, 7'd10};
    vecs[2] = '{3'd0, 3'd0, 7'd0};
    vecs[3] = '{3'd7, 3'd7, 7'd0};
    vecs[4] = '{3'd0, 3'd7, 7'd10};
    vecs[5] = '{3'd7, 3'd0, 7'd10};
    vecs[6] = '{3'd2, 3'd2, 7'd0};
    vecs[7] = '{3'd3, 3'd4, 7'd10};
    @(posedge CLK); #1;
    do_reset("reset");

    // Diagonal table with gapped load, reads, good result, then ignored inputs in DONE.
    fill_std();
    load(64, 1'b1);
    ld_valid = 1'b1; ld_data = '1;
    for (int i = 0; i < 8; i++)
      read_one($sformatf("rd_std_%0d", i), vecs[i].w, vecs[i].j, vecs[i].cost);
    ld_valid = 1'b0;
    send_result(10'd0, 4'd1);
    check("a_done",    done,    1);
    check("a_pass",    pass,    model_pass(10'd0, 4'd1));
    check("a_timeout", timeout, 0);
    check("a_cost_done", Cost,  0);
    check("a_jam_parked", jam_rst, 1);
    ld_valid = 1'b1;
    send_result(10'd7, 4'd3);
    ld_valid = 1'b0;
    check("a_ld_ready_done", ld_ready, 0);
    check("a_pass_hold", pass, 1);
    check("a_done_hold", done, 1);

    // Distinct-value table; wrong MinCost must fail and stay failed.
    do_reset("rst_b");
    for (int k = 0; k < 64; k++) tbl[k] = 7'((k * 37 + 5) & 127);
    load(64, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [5:0] a;
      a = 6'($urandom_range(0, 63));
      read_one($sformatf("rd_rand_%0d", i), a[5:3], a[2:0], tbl[a]);
    end
    send_result(10'd5, 4'd1);
    check("b_done",    done,    1);
    check("b_pass",    pass,    model_pass(10'd5, 4'd1));
    check("b_timeout", timeout, 0);
    send_result(10'd0, 4'd1);
    check("b_pass_hold", pass, 0);

    // Timeout after exactly TMO SERVE cycles.
    do_reset("rst_c");
    fill_std();
    load(64, 1'b0);
    run_edges(TMO - 1);
    check("c_done_before", done, 0);
    run_edges(1);
    check("c_done",    done,    1);
    check("c_timeout", timeout, 1);
    check("c_pass",    pass,    0);

    // Valid on the last SERVE cycle beats the timeout.
    do_reset("rst_d");
    load(64, 1'b0);
    run_edges(TMO - 1);
    send_result(10'd0, 4'd1);
    check("d_done",    done,    1);
    check("d_timeout", timeout, 0);
    check("d_pass",    pass,    1);

    // Reset after 30 words of stale data, then a full reload must win.
    do_reset("rst_e0");
    for (int k = 0; k < 64; k++) tbl[k] = 7'd99;
    load(30, 1'b0);
    do_reset("rst_mid_load");
    fill_std();
    load(64, 1'b1);
    for (int i = 0; i < 8; i++)
      read_one($sformatf("rd_reload_%0d", i), vecs[i].w, vecs[i].j, vecs[i].cost);
    send_result(10'd0, 4'd1);
    check("e_done", done, 1);
    check("e_pass", pass, 1);

    // Reset during SERVE parks the JAM and reopens the load port.
    do_reset("rst_f0");
    load(64, 1'b0);
    run_edges(5);
    do_reset("rst_mid_serve");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
